// File: rtl/ledpanel_pkg.sv
// rtl/ledpanel_pkg.sv - shared constants, op codes and state encoding for the LED panel drawing engine
package ledpanel_pkg;

    localparam int LEDPANEL_COORD_W = 5;
    localparam int LEDPANEL_SIZE    = 32;

    localparam logic OP_FILL  = 1'b0;
    localparam logic OP_CLEAR = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN
    } state_t;

endpackage

// File: rtl/ledpanel_gamma_lut.sv
// rtl/ledpanel_gamma_lut.sv - 8-bit gamma 2.2 ROM with one registered output stage
module ledpanel_gamma_lut (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    output logic [7:0] dout
);

    function automatic int gamma_entry(input int i);
        return $rtoi(255.0 * $pow(real'(i) / 255.0, 2.2) + 0.5);
    endfunction

    logic [7:0] rom [256];

    // Table contents are fixed at elaboration; lut[0]=0 and lut[255]=255 fall out of the curve.
    for (genvar i = 0; i < 256; i++) begin : g_rom
        localparam logic [7:0] ENTRY = 8'(gamma_entry(i));
        assign rom[i] = ENTRY;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout <= '0;
        end else begin
            dout <= rom[din];
        end
    end

endmodule

// File: rtl/ledpanel_rect_fill.sv
// rtl/ledpanel_rect_fill.sv - rectangle fill / clear engine feeding the panel pixel write port; optional LEDPANEL_RECT_FILL_GAMMA_EN
module ledpanel_rect_fill
    import ledpanel_pkg::*;
#(
    parameter int COORD_W = LEDPANEL_COORD_W,
    parameter int RGB_W   = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_op,
    input  logic [COORD_W-1:0] cmd_x0,
    input  logic [COORD_W-1:0] cmd_y0,
    input  logic [COORD_W-1:0] cmd_x1,
    input  logic [COORD_W-1:0] cmd_y1,
    input  logic [RGB_W-1:0]   cmd_rgb,
    output logic               wr_enable,
    output logic [COORD_W-1:0] wr_addr_x,
    output logic [COORD_W-1:0] wr_addr_y,
    output logic [RGB_W-1:0]   wr_rgb_data,
    output logic               done
);

    state_t state_q, state_d;

    logic [COORD_W-1:0] n_xl, n_xh, n_yl, n_yh;
    logic [RGB_W-1:0]   n_rgb;
    logic [COORD_W-1:0] xl_q, xh_q, yh_q;
    logic [COORD_W-1:0] cnt_x, cnt_y;
    logic [RGB_W-1:0]   colour_q;
    logic               issue_q;
    logic               done_q;
    logic               accept;
    logic               last;
    logic               done_set;

    assign cmd_ready = (state_q == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign last      = issue_q && (cnt_x == xh_q) && (cnt_y == yh_q);

    always_comb begin
        n_xl  = (cmd_x0 < cmd_x1) ? cmd_x0 : cmd_x1;
        n_xh  = (cmd_x0 < cmd_x1) ? cmd_x1 : cmd_x0;
        n_yl  = (cmd_y0 < cmd_y1) ? cmd_y0 : cmd_y1;
        n_yh  = (cmd_y0 < cmd_y1) ? cmd_y1 : cmd_y0;
        n_rgb = cmd_rgb;
        if (cmd_op == OP_CLEAR) begin
            n_xl  = '0;
            n_yl  = '0;
            n_xh  = '1;
            n_yh  = '1;
            n_rgb = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = FILL;
`ifdef LEDPANEL_RECT_FILL_GAMMA_EN
            FILL:    if (last) state_d = DRAIN;
`else
            FILL:    if (last) state_d = IDLE;
`endif
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef LEDPANEL_RECT_FILL_GAMMA_EN
    // The pipeline is a single stage deep, so one DRAIN cycle flushes it.
    assign done_set = (state_q == DRAIN);
`else
    assign done_set = last;
`endif

    // Counters stop on the last pixel instead of wrapping so the address outputs hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            issue_q  <= 1'b0;
            cnt_x    <= '0;
            cnt_y    <= '0;
            xl_q     <= '0;
            xh_q     <= '0;
            yh_q     <= '0;
            colour_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= done_set;
            if (accept) begin
                issue_q  <= 1'b1;
                cnt_x    <= n_xl;
                cnt_y    <= n_yl;
                xl_q     <= n_xl;
                xh_q     <= n_xh;
                yh_q     <= n_yh;
                colour_q <= n_rgb;
            end else if (issue_q) begin
                if (last) begin
                    issue_q <= 1'b0;
                end else if (cnt_x == xh_q) begin
                    cnt_x <= xl_q;
                    cnt_y <= cnt_y + 1'b1;
                end else begin
                    cnt_x <= cnt_x + 1'b1;
                end
            end
        end
    end

    assign done = done_q;

`ifdef LEDPANEL_RECT_FILL_GAMMA_EN
    logic               en_q;
    logic [COORD_W-1:0] ax_q, ay_q;
    logic [7:0]         g_r, g_g, g_b;

    ledpanel_gamma_lut u_gamma_r (.clk(clk), .reset(reset), .din(colour_q[23:16]), .dout(g_r));
    ledpanel_gamma_lut u_gamma_g (.clk(clk), .reset(reset), .din(colour_q[15:8]),  .dout(g_g));
    ledpanel_gamma_lut u_gamma_b (.clk(clk), .reset(reset), .din(colour_q[7:0]),   .dout(g_b));

    // Address and strobe are delayed to line up with the registered ROM output.
    always_ff @(posedge clk) begin
        if (reset) begin
            en_q <= 1'b0;
            ax_q <= '0;
            ay_q <= '0;
        end else begin
            en_q <= issue_q;
            ax_q <= cnt_x;
            ay_q <= cnt_y;
        end
    end

    assign wr_enable   = en_q;
    assign wr_addr_x   = ax_q;
    assign wr_addr_y   = ay_q;
    assign wr_rgb_data = {g_r, g_g, g_b};
`else
    assign wr_enable   = issue_q;
    assign wr_addr_x   = cnt_x;
    assign wr_addr_y   = cnt_y;
    assign wr_rgb_data = colour_q;
`endif

endmodule

// File: tb/tb_ledpanel_rect_fill.sv
// tb/tb_ledpanel_rect_fill.sv - directed self-checking bench for ledpanel_rect_fill
module tb_ledpanel_rect_fill;
    import ledpanel_pkg::*;

`ifdef LEDPANEL_RECT_FILL_GAMMA_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [4:0]  cmd_x0, cmd_y0, cmd_x1, cmd_y1;
    logic [23:0] cmd_rgb;
    logic        wr_enable;
    logic [4:0]  wr_addr_x, wr_addr_y;
    logic [23:0] wr_rgb_data;
    logic        done;

    ledpanel_rect_fill dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
        .cmd_rgb(cmd_rgb),
        .wr_enable(wr_enable), .wr_addr_x(wr_addr_x), .wr_addr_y(wr_addr_y),
        .wr_rgb_data(wr_rgb_data), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          wx[$];
    int          wy[$];
    int          wk[$];
    logic [23:0] wc[$];
    int          done_k;
    logic        ready_at_done;
    logic        en_at_done;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive_cmd(input logic op, input logic [4:0] x0, input logic [4:0] y0,
                             input logic [4:0] x1, input logic [4:0] y1, input logic [23:0] rgb);
        cmd_op  = op;
        cmd_x0  = x0;
        cmd_y0  = y0;
        cmd_x1  = x1;
        cmd_y1  = y1;
        cmd_rgb = rgb;
    endtask

    // k counts cycles after the accept edge; k=1 is the cycle right after accept.
    task automatic collect(input int budget);
        wx.delete(); wy.delete(); wk.delete(); wc.delete();
        done_k        = -1;
        ready_at_done = 1'b0;
        en_at_done    = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (wr_enable) begin
                wx.push_back(int'(wr_addr_x));
                wy.push_back(int'(wr_addr_y));
                wc.push_back(wr_rgb_data);
                wk.push_back(k);
            end
            if (done) begin
                done_k        = k;
                ready_at_done = cmd_ready;
                en_at_done    = wr_enable;
                break;
            end
        end
    endtask

    task automatic check_burst(input string tag, input int xl, input int xh, input int yl,
                               input int yh, input logic [23:0] rgb);
        int n;
        int idx;
        int errs;
        n    = (xh - xl + 1) * (yh - yl + 1);
        idx  = 0;
        errs = 0;
        for (int y = yl; y <= yh; y++) begin
            for (int x = xl; x <= xh; x++) begin
                if (idx < wx.size()) begin
                    if (wx[idx] != x || wy[idx] != y || wc[idx] !== rgb || wk[idx] != idx + LAT)
                        errs++;
                end else begin
                    errs++;
                end
                idx++;
            end
        end
        check({tag, "_count"}, wx.size(), n);
        check({tag, "_seq_errs"}, errs, 0);
        check({tag, "_done_cycle"}, done_k, n + LAT);
        check({tag, "_ready_at_done"}, ready_at_done, 1'b1);
        check({tag, "_en_at_done"}, en_at_done, 1'b0);
    endtask

    task automatic run_cmd(input string tag, input logic op, input logic [4:0] x0, input logic [4:0] y0,
                           input logic [4:0] x1, input logic [4:0] y1, input logic [23:0] rgb);
        @(negedge clk);
        drive_cmd(op, x0, y0, x1, y1, rgb);
        cmd_valid = 1'b1;
        check({tag, "_ready_before"}, cmd_ready, 1'b1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        collect(1200);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits [32][32];
        int bad;
        int cnt;
        int seen;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        drive_cmd(OP_FILL, 5'd0, 5'd0, 5'd0, 5'd0, 24'h0);
        repeat (3) @(negedge clk);
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_wr_enable", wr_enable, 1'b0);
        check("rst_addr_x", wr_addr_x, 5'd0);
        check("rst_addr_y", wr_addr_y, 5'd0);
        check("rst_rgb", wr_rgb_data, 24'h0);
        check("rst_done", done, 1'b0);
        reset = 1'b0;

        run_cmd("t1", OP_FILL, 5'd2, 5'd3, 5'd4, 5'd3, 24'hFF0000);
        check_burst("t1", 2, 4, 3, 3, 24'hFF0000);

        run_cmd("t2", OP_FILL, 5'd5, 5'd6, 5'd5, 5'd6, 24'h00FF00);
        check_burst("t2", 5, 5, 6, 6, 24'h00FF00);

        run_cmd("t3rev", OP_FILL, 5'd7, 5'd9, 5'd6, 5'd8, 24'h0000FF);
        check_burst("t3rev", 6, 7, 8, 9, 24'h0000FF);
        run_cmd("t3fwd", OP_FILL, 5'd6, 5'd8, 5'd7, 5'd9, 24'h0000FF);
        check_burst("t3fwd", 6, 7, 8, 9, 24'h0000FF);

        run_cmd("t4", OP_CLEAR, 5'd3, 5'd4, 5'd10, 5'd12, 24'hABCDEF);
        check_burst("t4", 0, 31, 0, 31, 24'h0);
        for (int i = 0; i < 32; i++)
            for (int j = 0; j < 32; j++)
                hits[i][j] = 0;
        foreach (wx[i]) hits[wx[i]][wy[i]]++;
        bad = 0;
        for (int i = 0; i < 32; i++)
            for (int j = 0; j < 32; j++)
                if (hits[i][j] != 1) bad++;
        check("t4_map_bad_cells", bad, 0);

        @(negedge clk);
        drive_cmd(OP_FILL, 5'd1, 5'd1, 5'd3, 5'd1, 24'hFFFFFF);
        cmd_valid = 1'b1;
        check("t5a_ready_before", cmd_ready, 1'b1);
        @(posedge clk);
        #1 drive_cmd(OP_FILL, 5'd0, 5'd2, 5'd1, 5'd3, 24'hFF0000);
        collect(50);
        check_burst("t5a", 1, 3, 1, 1, 24'hFFFFFF);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        collect(50);
        check_burst("t5b", 0, 1, 2, 3, 24'hFF0000);

        @(negedge clk);
        drive_cmd(OP_CLEAR, 5'd0, 5'd0, 5'd0, 5'd0, 24'h0);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (wr_enable) cnt++;
            if (cnt == 10) break;
        end
        check("t6_writes_before_reset", cnt, 10);
        reset = 1'b1;
        @(negedge clk);
        check("t6_wr_enable_after_reset", wr_enable, 1'b0);
        check("t6_ready_after_reset", cmd_ready, 1'b1);
        check("t6_done_after_reset", done, 1'b0);
        reset = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || wr_enable) seen++;
        end
        check("t6_quiet_after_reset", seen, 0);
        run_cmd("t6f", OP_FILL, 5'd2, 5'd3, 5'd4, 5'd3, 24'hFF0000);
        check_burst("t6f", 2, 4, 3, 3, 24'hFF0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
